// File: rtl/uart_tx_engine.sv
// -----------------------------------------------------------------------------
// uart_tx_engine
//   UART transmit engine. It is paced by en_tx, which pulses OVERSAMPLE times
//   per bit. Bytes arrive on a valid/ready handshake into a one-entry holding
//   register. Each byte is sent on txd LSB first: a start bit, DATA_BITS data
//   bits, an optional parity bit, then STOP_BITS stop bits. The idle line is
//   high.
//
//   Optional feature: define UART_TX_PARITY_EN to add the parity_odd input and
//   a PARITY state after DATA.
//
// Ports
//   clk         UART clock
//   rst         synchronous, active-high reset
//   en_tx       one-clk tick from the baud divisor, OVERSAMPLE ticks per bit
//   tx_data     byte to send (DATA_BITS wide)
//   tx_valid    tx_data is valid
//   tx_ready    holding register empty; byte taken when tx_valid && tx_ready
//   parity_odd  (UART_TX_PARITY_EN only) 1 = odd parity, 0 = even parity
//   txd         registered serial output
//   busy        frame in progress or holding register full
// -----------------------------------------------------------------------------
module uart_tx_engine #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16,
   parameter int STOP_BITS  = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en_tx,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
`ifdef UART_TX_PARITY_EN
   input  logic                 parity_odd,
`endif
   output logic                 txd,
   output logic                 busy
);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

   localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
   localparam logic [2:0] DATA_LAST = 3'(DATA_BITS - 1);
   localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

   state_t               state_r;
   logic [3:0]           tick_cnt_r;
   logic [2:0]           bit_cnt_r;
   logic [DATA_BITS-1:0] shift_r;
   logic [DATA_BITS-1:0] hold_r;
   logic                 hold_full_r;
   logic                 tx_ready_r;
   logic                 txd_r;
   logic                 busy_r;
`ifdef UART_TX_PARITY_EN
   logic                 parity_r;
`endif

   logic bit_end_s;
   logic accept_s;
   logic load_s;

   // The current bit ends on the en_tx tick that would take tick_cnt to OVERSAMPLE.
   assign bit_end_s = en_tx && (tick_cnt_r == TICK_LAST);
   assign accept_s  = tx_valid && tx_ready_r;
   // Load the shifter from IDLE, or straight from the end of the last stop bit,
   // so that back-to-back frames have no idle gap. accept_s and load_s are never
   // both true: accept needs an empty holding register, load needs a full one.
   assign load_s    = hold_full_r && en_tx &&
                      ((state_r == IDLE) ||
                       ((state_r == STOP) && bit_end_s && (bit_cnt_r == STOP_LAST)));

   // Frame sequencer, bit timing, holding register and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         tick_cnt_r  <= 4'd0;
         bit_cnt_r   <= 3'd0;
         shift_r     <= '0;
         hold_r      <= '0;
         hold_full_r <= 1'b0;
         tx_ready_r  <= 1'b1;
         txd_r       <= 1'b1;
         busy_r      <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_r    <= 1'b0;
`endif
      end else begin
         if ((state_r != IDLE) && en_tx) begin
            tick_cnt_r <= bit_end_s ? 4'd0 : tick_cnt_r + 4'd1;
         end

         if (load_s) begin
            state_r     <= START;
            shift_r     <= hold_r;
            hold_full_r <= 1'b0;
            tx_ready_r  <= 1'b1;
            txd_r       <= 1'b0;
            tick_cnt_r  <= 4'd0;
            bit_cnt_r   <= 3'd0;
`ifdef UART_TX_PARITY_EN
            // Parity is fixed for the frame at load time.
            parity_r    <= (^hold_r) ^ parity_odd;
`endif
         end else if (bit_end_s) begin
            case (state_r)
               START: begin
                  state_r   <= DATA;
                  txd_r     <= shift_r[0];
                  bit_cnt_r <= 3'd0;
               end
               DATA: begin
                  if (bit_cnt_r == DATA_LAST) begin
                     bit_cnt_r <= 3'd0;
`ifdef UART_TX_PARITY_EN
                     state_r   <= PARITY;
                     txd_r     <= parity_r;
`else
                     state_r   <= STOP;
                     txd_r     <= 1'b1;
`endif
                  end else begin
                     // shift_r[1] becomes the new LSB after this shift.
                     shift_r   <= shift_r >> 1;
                     txd_r     <= shift_r[1];
                     bit_cnt_r <= bit_cnt_r + 3'd1;
                  end
               end
`ifdef UART_TX_PARITY_EN
               PARITY: begin
                  state_r   <= STOP;
                  txd_r     <= 1'b1;
                  bit_cnt_r <= 3'd0;
               end
`endif
               STOP: begin
                  // bit_cnt counts stop bits here; the last one with an
                  // empty holding register returns to IDLE.
                  if (bit_cnt_r != STOP_LAST) begin
                     bit_cnt_r <= bit_cnt_r + 3'd1;
                  end else begin
                     state_r   <= IDLE;
                     txd_r     <= 1'b1;
                     bit_cnt_r <= 3'd0;
                     busy_r    <= 1'b0;
                  end
               end
               default: begin
                  state_r <= IDLE;
                  txd_r   <= 1'b1;
               end
            endcase
         end

         // A byte accepted on the edge that returns to IDLE keeps busy high.
         if (accept_s) begin
            hold_r      <= tx_data;
            hold_full_r <= 1'b1;
            tx_ready_r  <= 1'b0;
            busy_r      <= 1'b1;
         end
      end
   end

   assign tx_ready = tx_ready_r;
   assign txd      = txd_r;
   assign busy     = busy_r;

endmodule

// File: tb/tb_uart_tx_engine.sv
module tb_uart_tx_engine;

   logic       clk = 1'b0;
   logic       rst;
   logic       en_tx;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       parity_odd;
   logic       txd1, busy1, ready1;
   logic       txd2, busy2, ready2;
   logic       sel;
   logic       en_off, en_div4;
   logic [1:0] en_cnt = 2'd0;
   logic       txd_o, busy_o, ready_o;
   int         vecs = 0;
   int         errs = 0;

   always #5 clk = ~clk;

   always @(posedge clk) en_cnt <= en_cnt + 2'd1;
   assign en_tx = en_off ? 1'b0 : (en_div4 ? (en_cnt == 2'd0) : 1'b1);

   assign txd_o   = sel ? txd2   : txd1;
   assign busy_o  = sel ? busy2  : busy1;
   assign ready_o = sel ? ready2 : ready1;

   uart_tx_engine dut1 (
      .clk(clk), .rst(rst), .en_tx(en_tx), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(ready1),
`ifdef UART_TX_PARITY_EN
      .parity_odd(parity_odd),
`endif
      .txd(txd1), .busy(busy1));

   uart_tx_engine #(.DATA_BITS(7), .OVERSAMPLE(16), .STOP_BITS(2)) dut2 (
      .clk(clk), .rst(rst), .en_tx(en_tx), .tx_data(tx_data[6:0]), .tx_valid(tx_valid),
      .tx_ready(ready2),
`ifdef UART_TX_PARITY_EN
      .parity_odd(parity_odd),
`endif
      .txd(txd2), .busy(busy2));

   // Wait for tx_ready, then present one byte for exactly one accepting edge.
   task automatic accept(input logic [7:0] b);
      bit ok = 1'b0;
      for (int w = 0; w < 400; w++) begin
         if (ready_o === 1'b1) begin ok = 1'b1; break; end
         @(posedge clk); #1;
      end
      vecs++;
      if (!ok) begin
         errs++;
         $display("FAIL accept_timeout: tx_ready=%b after 400 clk, required 1", ready_o);
      end
      tx_data  = b;
      tx_valid = 1'b1;
      @(posedge clk); #1;
      tx_valid = 1'b0;
   endtask

   // Follow one frame cycle by cycle. fb: bit index that gets a 100-clk en_tx
   // freeze (-1 none). inj_b: bit index where a second byte is offered (-1 none).
   task automatic check_frame(input logic [7:0] data, input int nd, input int ns,
                              input logic par, input int bitlen, input int max_wait,
                              input int exp_lat, input int fb, input int inj_b,
                              input logic [7:0] inj_d);
      logic bits [12];
      int   nb, lat, len;
      bit   found, injected;
      bits[0] = 1'b0;
      for (int i = 0; i < nd; i++) bits[1 + i] = data[i];
      nb = 1 + nd;
`ifdef UART_TX_PARITY_EN
      bits[nb] = par;
      nb++;
`endif
      for (int i = 0; i < ns; i++) begin bits[nb] = 1'b1; nb++; end

      found = 1'b0;
      lat = 0;
      injected = 1'b0;
      for (int w = 1; w <= max_wait; w++) begin
         @(posedge clk); #1;
         if (txd_o === 1'b0) begin found = 1'b1; lat = w; break; end
      end
      vecs++;
      if (!found) begin
         errs++;
         $display("FAIL start_timeout: txd=%b after %0d clk, required 0", txd_o, max_wait);
         return;
      end
      if (exp_lat > 0) begin
         vecs++;
         if (lat !== exp_lat) begin
            errs++;
            $display("FAIL start_latency: got %0d clk, required %0d", lat, exp_lat);
         end
      end
      vecs++;
      if (ready_o !== 1'b1) begin
         errs++;
         $display("FAIL ready_after_load: got %b, required 1", ready_o);
      end

      for (int b = 0; b < nb; b++) begin
         len = bitlen + ((b == fb) ? 100 : 0);
         for (int c = 1; c <= len; c++) begin
            if (!(b == 0 && c == 1)) begin
               @(posedge clk); #1;
            end
            if (injected) begin
               tx_valid = 1'b0;
               vecs++;
               if (ready_o !== 1'b0) begin
                  errs++;
                  $display("FAIL ready_pending: bit %0d clk %0d got %b, required 0", b, c, ready_o);
               end
            end
            if (b == inj_b && c == 5) begin
               tx_data  = inj_d;
               tx_valid = 1'b1;
               injected = 1'b1;
            end
            vecs++;
            if (txd_o !== bits[b]) begin
               errs++;
               $display("FAIL txd_bit: bit %0d clk %0d got %b, required %b", b, c, txd_o, bits[b]);
            end
            vecs++;
            if (busy_o !== 1'b1) begin
               errs++;
               $display("FAIL busy_frame: bit %0d clk %0d got %b, required 1", b, c, busy_o);
            end
            if (b == fb && c == 10)  en_off = 1'b1;
            if (b == fb && c == 110) en_off = 1'b0;
         end
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; parity_odd = 1'b0;
      sel = 1'b0; en_off = 1'b0; en_div4 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      vecs++;
      if (txd_o !== 1'b1 || ready_o !== 1'b1 || busy_o !== 1'b0) begin
         errs++;
         $display("FAIL reset_state: txd=%b ready=%b busy=%b, required 1 1 0", txd_o, ready_o, busy_o);
      end
      rst = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      vecs++;
      if (txd_o !== 1'b1 || busy_o !== 1'b0) begin
         errs++;
         $display("FAIL idle_after_reset: txd=%b busy=%b, required 1 0", txd_o, busy_o);
      end
   endtask

   task automatic test_basic;
      accept(8'h55);
      vecs++;
      if (ready_o !== 1'b0 || busy_o !== 1'b1) begin
         errs++;
         $display("FAIL accept_flags: ready=%b busy=%b, required 0 1", ready_o, busy_o);
      end
      check_frame(8'h55, 8, 1, 1'b0, 16, 1, 1, -1, -1, 8'h00);
      @(posedge clk); #1;
      vecs++;
      if (busy_o !== 1'b0 || ready_o !== 1'b1 || txd_o !== 1'b1) begin
         errs++;
         $display("FAIL basic_end: busy=%b ready=%b txd=%b, required 0 1 1", busy_o, ready_o, txd_o);
      end
   endtask

   task automatic test_back_to_back;
      accept(8'hA3);
      check_frame(8'hA3, 8, 1, 1'b0, 16, 1, 1, -1, 3, 8'h0F);
      check_frame(8'h0F, 8, 1, 1'b0, 16, 1, 1, -1, -1, 8'h00);
      @(posedge clk); #1;
      vecs++;
      if (busy_o !== 1'b0 || txd_o !== 1'b1) begin
         errs++;
         $display("FAIL b2b_end: busy=%b txd=%b, required 0 1", busy_o, txd_o);
      end
   endtask

   task automatic test_en_tx_pacing;
      en_div4 = 1'b1;
      accept(8'h55);
      check_frame(8'h55, 8, 1, 1'b0, 64, 8, -1, -1, -1, 8'h00);
      @(posedge clk); #1;
      vecs++;
      if (busy_o !== 1'b0) begin
         errs++;
         $display("FAIL div4_end: busy=%b, required 0", busy_o);
      end
      accept(8'h55);
      check_frame(8'h55, 8, 1, 1'b0, 64, 8, -1, 2, -1, 8'h00);
      @(posedge clk); #1;
      vecs++;
      if (busy_o !== 1'b0 || txd_o !== 1'b1) begin
         errs++;
         $display("FAIL freeze_end: busy=%b txd=%b, required 0 1", busy_o, txd_o);
      end
      en_div4 = 1'b0;
   endtask

   task automatic test_reset_mid_frame;
      bit found = 1'b0;
      accept(8'hFF);
      for (int w = 0; w < 4; w++) begin
         @(posedge clk); #1;
         if (txd_o === 1'b0) begin found = 1'b1; break; end
      end
      vecs++;
      if (!found) begin
         errs++;
         $display("FAIL ff_start: txd=%b, required 0", txd_o);
      end
      repeat (5) @(posedge clk);
      #1;
      tx_data = 8'h3C; tx_valid = 1'b1;
      @(posedge clk); #1;
      tx_valid = 1'b0;
      vecs++;
      if (ready_o !== 1'b0) begin
         errs++;
         $display("FAIL pending_accept: ready=%b, required 0", ready_o);
      end
      repeat (33) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      vecs++;
      if (txd_o !== 1'b1 || busy_o !== 1'b0 || ready_o !== 1'b1) begin
         errs++;
         $display("FAIL mid_reset: txd=%b busy=%b ready=%b, required 1 0 1", txd_o, busy_o, ready_o);
      end
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         vecs++;
         if (txd_o !== 1'b1 || busy_o !== 1'b0) begin
            errs++;
            $display("FAIL discard: clk %0d txd=%b busy=%b, required 1 0", i, txd_o, busy_o);
         end
      end
      accept(8'h81);
      check_frame(8'h81, 8, 1, 1'b0, 16, 1, 1, -1, -1, 8'h00);
      @(posedge clk); #1;
      vecs++;
      if (busy_o !== 1'b0 || txd_o !== 1'b1) begin
         errs++;
         $display("FAIL fresh_end: busy=%b txd=%b, required 0 1", busy_o, txd_o);
      end
   endtask

`ifdef UART_TX_PARITY_EN
   task automatic test_parity;
      parity_odd = 1'b0;
      accept(8'h07);
      check_frame(8'h07, 8, 1, 1'b1, 16, 1, 1, -1, -1, 8'h00);
      @(posedge clk); #1;
      parity_odd = 1'b1;
      accept(8'h07);
      check_frame(8'h07, 8, 1, 1'b0, 16, 1, 1, -1, -1, 8'h00);
      @(posedge clk); #1;
      vecs++;
      if (busy_o !== 1'b0) begin
         errs++;
         $display("FAIL parity_end: busy=%b, required 0", busy_o);
      end
      parity_odd = 1'b0;
   endtask
`endif

   task automatic test_seven_two;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      sel = 1'b1;
      accept(8'h7F);
      check_frame(8'h7F, 7, 2, 1'b1, 16, 1, 1, -1, -1, 8'h00);
      @(posedge clk); #1;
      vecs++;
      if (busy_o !== 1'b0 || txd_o !== 1'b1 || ready_o !== 1'b1) begin
         errs++;
         $display("FAIL seven_two_end: busy=%b txd=%b ready=%b, required 0 1 1", busy_o, txd_o, ready_o);
      end
      sel = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_en_tx_pacing();
      test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
      test_parity();
`endif
      test_seven_two();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded 1000000 time units");
      $fatal(1, "watchdog");
   end

endmodule
